// File: rtl/alsu_pipe.sv
// alsu_pipe: two-stage, valid-gated arithmetic/logic/shift unit.
// Stage 1 captures operands and controls when in_valid is high. Stage 2
// executes the captured operation and drives out, err, leds and a
// one-cycle out_valid strobe. Opcodes 4-6 operate on the current out
// register, so back-to-back shift/rotate/accumulate operations chain.
module alsu_pipe #(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [WIDTH-1:0]     A,
    input  logic signed [WIDTH-1:0]     B,
    input  logic                        cin,
    input  logic                        serial_in,
    input  logic                        red_op_A,
    input  logic                        red_op_B,
    input  logic [2:0]                  opcode,
    input  logic                        bypass_A,
    input  logic                        bypass_B,
    input  logic                        direction,
    output logic                        out_valid,
    output logic signed [2*WIDTH-1:0]   out,
    output logic                        err,
    output logic [LED_WIDTH-1:0]        leds
);

    localparam int W2      = 2 * WIDTH;
    // Elaboration-time decode of the string parameters.
    localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
    localparam bit USE_CIN = (FULL_ADDER == "ON");

    typedef enum logic [2:0] {
        OP_OR    = 3'd0,
        OP_XOR   = 3'd1,
        OP_ADD   = 3'd2,
        OP_MUL   = 3'd3,
        OP_SHIFT = 3'd4,
        OP_ROT   = 3'd5,
        OP_ACC   = 3'd6,
        OP_RSVD  = 3'd7
    } opcode_e;

    // ------------------------------------------------------------------
    // Stage 1: captured inputs
    // ------------------------------------------------------------------
    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] b_q;
    logic                    cin_q;
    logic                    ser_q;
    logic                    red_a_q;
    logic                    red_b_q;
    opcode_e                 op_q;
    logic                    byp_a_q;
    logic                    byp_b_q;
    logic                    dir_q;
    logic                    v1;

    // Capture all operands and controls on a valid cycle; v1 tracks whether
    // stage 2 has work on the next edge.
    // NOTE: sequential state is written with <= so every register samples
    // the pre-edge values; blocking = here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here is a flop (no memory arrays), so all of
        // them are cleared by the asynchronous reset.
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            ser_q   <= 1'b0;
            red_a_q <= 1'b0;
            red_b_q <= 1'b0;
            op_q    <= OP_OR;
            byp_a_q <= 1'b0;
            byp_b_q <= 1'b0;
            dir_q   <= 1'b0;
            v1      <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                a_q     <= A;
                b_q     <= B;
                cin_q   <= cin;
                ser_q   <= serial_in;
                red_a_q <= red_op_A;
                red_b_q <= red_op_B;
                op_q    <= opcode_e'(opcode);
                byp_a_q <= bypass_A;
                byp_b_q <= bypass_B;
                dir_q   <= direction;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: combinational execute
    // ------------------------------------------------------------------
    logic signed [W2-1:0] a_ext;
    logic signed [W2-1:0] b_ext;
    logic                 red_any;
    logic                 byp_any;
    logic                 invalid;
    logic                 red_a_bit;
    logic                 red_b_bit;
    logic                 red_bit;
    logic [W2-1:0]        carry_ext;
    logic signed [W2-1:0] op_res;
    logic signed [W2-1:0] next_out;
    logic                 next_err;

    assign a_ext     = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_ext     = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign red_any   = red_a_q | red_b_q;
    assign byp_any   = byp_a_q | byp_b_q;
    assign invalid   = (red_any && (op_q != OP_OR) && (op_q != OP_XOR)) ||
                       (op_q == OP_RSVD);
    assign carry_ext = {{(W2-1){1'b0}}, cin_q & USE_CIN};

    // Pick the reduction bit for OR/XOR, honouring the priority operand
    // when both reduction flags are set.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        red_a_bit = |a_q;
        red_b_bit = |b_q;
        red_bit   = 1'b0;
        if (op_q == OP_XOR) begin
            red_a_bit = ^a_q;
            red_b_bit = ^b_q;
        end
        if (red_a_q && red_b_q) begin
            red_bit = PRIO_A ? red_a_bit : red_b_bit;
        end else if (red_a_q) begin
            red_bit = red_a_bit;
        end else begin
            red_bit = red_b_bit;
        end
    end

    // Opcode datapath; shift, rotate and accumulate read the live out
    // register so consecutive operations chain.
    always_comb begin
        op_res = '0;
        case (op_q)
            OP_OR: begin
                if (red_any) op_res = {{(W2-1){1'b0}}, red_bit};
                else         op_res = a_ext | b_ext;
            end
            OP_XOR: begin
                if (red_any) op_res = {{(W2-1){1'b0}}, red_bit};
                else         op_res = a_ext ^ b_ext;
            end
            OP_ADD: begin
                // |sum| <= 2^W, well inside the 2W-bit range.
                op_res = a_ext + b_ext + carry_ext;
            end
            OP_MUL: begin
                // Both factors are sign-extended to 2W, so the truncated
                // product is the exact signed W x W result.
                op_res = a_ext * b_ext;
            end
            OP_SHIFT: begin
                if (dir_q) op_res = {out[W2-2:0], ser_q};
                else       op_res = {ser_q, out[W2-1:1]};
            end
            OP_ROT: begin
                if (dir_q) op_res = {out[W2-2:0], out[W2-1]};
                else       op_res = {out[0], out[W2-1:1]};
            end
            OP_ACC: begin
                op_res = out + a_ext;
            end
            OP_RSVD: begin
                op_res = '0;
            end
        endcase
    end

    // Result priority: bypass beats invalidity, invalidity beats the opcode.
    always_comb begin
        next_out = op_res;
        next_err = 1'b0;
        if (byp_a_q && byp_b_q) begin
            next_out = PRIO_A ? a_ext : b_ext;
        end else if (byp_a_q) begin
            next_out = a_ext;
        end else if (byp_b_q) begin
            next_out = b_ext;
        end else if (invalid) begin
            next_out = '0;
            next_err = 1'b1;
        end
    end

    // Commit the executed operation; with no work in stage 2 everything
    // holds and the strobe drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            err       <= 1'b0;
            leds      <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                out  <= next_out;
                err  <= next_err;
                leds <= invalid ? ~leds : '0;
            end
        end
    end

endmodule

// File: tb/tb_alsu_pipe.sv
// tb_alsu_pipe: directed scenarios plus randomized traffic for two
// alsu_pipe instances (priority A / full adder on, priority B / adder off)
// checked against an arithmetic reference model.
module tb_alsu_pipe;

    localparam int W    = 3;
    localparam int W2   = 2 * W;
    localparam int LW   = 16;
    localparam int MASK = (1 << W2) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, cin, serial_in, red_op_A, red_op_B;
    logic          bypass_A, bypass_B, direction;
    logic [W-1:0]  A, B;
    logic [2:0]    opcode;

    logic          ov0, ov1, err0, err1;
    logic [W2-1:0] out0, out1;
    logic [LW-1:0] leds0, leds1;

    always #5 clk = ~clk;

    alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_WIDTH(LW)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .cin(cin),
        .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .opcode(opcode), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .direction(direction), .out_valid(ov0), .out(out0), .err(err0), .leds(leds0)
    );

    alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .LED_WIDTH(LW)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .cin(cin),
        .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .opcode(opcode), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .direction(direction), .out_valid(ov1), .out(out1), .err(err1), .leds(leds1)
    );

    typedef struct {
        bit v;
        int a, b, op;
        bit cin, ser, ra, rb, ba, bb, dir;
    } op_t;

    int            passed = 0;
    int            total  = 0;
    int            m_out  [2];
    bit            m_err  [2];
    logic [LW-1:0] m_leds [2];
    op_t           pend;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic int sval(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    // Reference model: one executed operation on instance k, as plain
    // integer arithmetic on the result value.
    function automatic void model_step(input int k, input op_t p);
        bit prio_a  = (k == 0);
        bit use_cin = (k == 0);
        int sa = sval(p.a);
        int sb = sval(p.b);
        bit invalid = ((p.ra || p.rb) && p.op > 1) || p.op == 7;
        bit ra_v, rb_v;
        int r = 0;
        int o = m_out[k];
        if (p.op == 1) begin
            ra_v = ($countones(p.a) % 2) == 1;
            rb_v = ($countones(p.b) % 2) == 1;
        end else begin
            ra_v = p.a != 0;
            rb_v = p.b != 0;
        end
        if (p.ba && p.bb)  r = prio_a ? sa : sb;
        else if (p.ba)     r = sa;
        else if (p.bb)     r = sb;
        else if (invalid)  r = 0;
        else begin
            case (p.op)
                0, 1: begin
                    if (p.ra && p.rb) r = prio_a ? int'(ra_v) : int'(rb_v);
                    else if (p.ra)    r = int'(ra_v);
                    else if (p.rb)    r = int'(rb_v);
                    else if (p.op == 0) r = sval(p.a | p.b);
                    else                r = sval(p.a ^ p.b);
                end
                2: r = sa + sb + (use_cin ? int'(p.cin) : 0);
                3: r = sa * sb;
                4: r = p.dir ? ((o << 1) | int'(p.ser))
                             : ((int'(p.ser) << (W2 - 1)) | (o >> 1));
                5: r = p.dir ? ((o << 1) | (o >> (W2 - 1)))
                             : (((o & 1) << (W2 - 1)) | (o >> 1));
                6: r = o + sa;
                default: r = 0;
            endcase
        end
        m_out[k]  = r & MASK;
        m_err[k]  = invalid && !(p.ba || p.bb);
        m_leds[k] = invalid ? ~m_leds[k] : '0;
    endfunction

    task automatic drive(input bit v, input int op = 0, input int a = 0, input int b = 0,
                         input bit c = 0, input bit ser = 0, input bit ra = 0,
                         input bit rb = 0, input bit ba = 0, input bit bb = 0,
                         input bit dir = 0);
        in_valid  = v;
        opcode    = 3'(op);
        A         = W'(a);
        B         = W'(b);
        cin       = c;
        serial_in = ser;
        red_op_A  = ra;
        red_op_B  = rb;
        bypass_A  = ba;
        bypass_B  = bb;
        direction = dir;
    endtask

    // One clock: retire the pending operation into the model, capture the
    // currently driven inputs as the new pending one, then compare.
    task automatic tick();
        bit exp_ov;
        @(posedge clk);
        if (pend.v) begin
            model_step(0, pend);
            model_step(1, pend);
        end
        exp_ov   = pend.v;
        pend.v   = in_valid;
        pend.a   = int'(A);
        pend.b   = int'(B);
        pend.op  = int'(opcode);
        pend.cin = cin;
        pend.ser = serial_in;
        pend.ra  = red_op_A;
        pend.rb  = red_op_B;
        pend.ba  = bypass_A;
        pend.bb  = bypass_B;
        pend.dir = direction;
        #1;
        chk("ov0",   32'(ov0),   32'(exp_ov));
        chk("out0",  32'(out0),  32'(m_out[0]));
        chk("err0",  32'(err0),  32'(m_err[0]));
        chk("leds0", 32'(leds0), 32'(m_leds[0]));
        chk("ov1",   32'(ov1),   32'(exp_ov));
        chk("out1",  32'(out1),  32'(m_out[1]));
        chk("err1",  32'(err1),  32'(m_err[1]));
        chk("leds1", 32'(leds1), 32'(m_leds[1]));
    endtask

    task automatic model_reset();
        pend.v = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_out[k]  = 0;
            m_err[k]  = 1'b0;
            m_leds[k] = '0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out0"},  32'(out0),  0);
        chk({tag, "_ov0"},   32'(ov0),   0);
        chk({tag, "_err0"},  32'(err0),  0);
        chk({tag, "_leds0"}, 32'(leds0), 0);
        chk({tag, "_out1"},  32'(out1),  0);
        chk({tag, "_ov1"},   32'(ov1),   0);
        chk({tag, "_err1"},  32'(err1),  0);
        chk({tag, "_leds1"}, 32'(leds1), 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // Signed multiply: -3 * 2 = -6, strobe two edges after capture.
        drive(1, 3, -3, 2);
        tick();
        drive(0);
        tick();
        chk("mul_out", 32'(out0), 32'(6'b111010));
        chk("mul_ov",  32'(ov0),  1);
        tick();
        chk("mul_ov_drop", 32'(ov0), 0);

        // Add with carry-in; the second instance ignores cin.
        drive(1, 2, 3, 3, 1);
        tick();
        drive(0);
        tick();
        chk("add_cin_on",  32'(out0), 7);
        chk("add_cin_off", 32'(out1), 6);

        // Two invalid ops then a valid OR.
        drive(1, 7, 1, 1);
        tick();
        tick();
        chk("inv1_err",  32'(err0),  1);
        chk("inv1_leds", 32'(leds0), 32'h0000_FFFF);
        drive(1, 0, 1, 0);
        tick();
        chk("inv2_leds", 32'(leds0), 0);
        chk("inv2_out",  32'(out0),  0);
        drive(0);
        tick();
        chk("or_err",  32'(err0), 0);
        chk("or_out",  32'(out0), 1);

        // Bypass, shift left, rotate right.
        drive(1, 0, 3, 0, .ba(1));
        tick();
        drive(1, 4, 0, 0, .ser(1), .dir(1));
        tick();
        chk("byp_out", 32'(out0), 32'(6'b000011));
        drive(1, 5, 0, 0, .dir(0));
        tick();
        chk("shl_out", 32'(out0), 32'(6'b000111));
        drive(0);
        tick();
        chk("ror_out", 32'(out0), 32'(6'b100011));

        // Accumulate -1 twice from zero with a gap in between.
        drive(1, 0, 0, 0, .ba(1));
        tick();
        drive(1, 6, -1);
        tick();
        drive(0);
        tick();
        chk("acc1_out", 32'(out0), 32'(6'b111111));
        tick();
        chk("gap_out", 32'(out0), 32'(6'b111111));
        chk("gap_ov",  32'(ov0),  0);
        drive(1, 6, -1);
        tick();
        drive(0);
        tick();
        chk("acc2_out", 32'(out0), 32'(6'b111110));

        // Asynchronous reset with an operation in flight.
        drive(1, 3, 3, 3);
        tick();
        #2 rst = 1'b1;
        #1;
        chk_zero("midrst");
        model_reset();
        drive(0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_ov", 32'(ov0), 0);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(3, 0) != 0,
                  int'($urandom_range(7, 0)),
                  int'($urandom_range(7, 0)),
                  int'($urandom_range(7, 0)),
                  $urandom_range(1, 0) == 1,
                  $urandom_range(1, 0) == 1,
                  $urandom_range(3, 0) == 0,
                  $urandom_range(3, 0) == 0,
                  $urandom_range(7, 0) == 0,
                  $urandom_range(7, 0) == 0,
                  $urandom_range(1, 0) == 1);
            tick();
        end
        drive(0);
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alsu_pipe.md
# alsu_pipe

Parametrised, handshake-gated successor to the team's 3-bit ALSU, sitting in the same datapath slot. Operands are W-bit signed and results are 2W-bit signed. Inputs are captured only when `in_valid` is high, and each captured operation yields one `out_valid` pulse two edges later. Adds a signed accumulate opcode and a registered error flag next to the LED blink indication.

## Interface
- `WIDTH`, 3: operand width W (W ≥ 2); result width is 2W.
- `INPUT_PRIORITY`, "A": operand that wins when both bypass flags or both reduction flags are set ("A" or "B").
- `FULL_ADDER`, "ON": "ON" adds `cin` on opcode 2; "OFF" ignores it.
- `LED_WIDTH`, 16: width of `leds`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: qualifies all operand and control inputs for capture.
- `A`, `B` in W: signed operands.
- `cin` in 1: unsigned carry-in (0/1).
- `serial_in` in 1: shift-in bit for opcode 4.
- `red_op_A`, `red_op_B` in 1: reduction selects.
- `opcode` in 3: operation select.
- `bypass_A`, `bypass_B` in 1: bypass selects.
- `direction` in 1: 1 = left, 0 = right.
- `out_valid` out 1: one-cycle result strobe.
- `out` out 2W: signed result register.
- `err` out 1: set when the last completed operation was invalid.
- `leds` out LED_WIDTH: error blink pattern.

## Operation
- Stage 1, capture: when `in_valid` is high, all inputs are registered and `v1` is set to 1. When it is low, `v1` is set to 0 and the input registers hold.
- Stage 2, execute: runs only when `v1` = 1. It updates `out`, `err`, and `leds`, and sets `out_valid` to 1. When `v1` = 0, `out`, `err`, and `leds` hold and `out_valid` goes to 0.
- Invalid operation: a reduction flag is set with opcode ∉ {0,1}, or opcode = 7.
- Priority order (highest first):
  - Both bypass flags set: the `INPUT_PRIORITY` operand.
  - One bypass flag set: that operand.
  - Invalid: `out` = 0 and `err` = 1.
  - Otherwise: the opcode result, with `err` = 0.
- Bypass ignores invalidity: `err` = 0 and `leds` follow the invalid rule below.
- `leds` on an executed operation: invert if invalid, otherwise clear to 0.
- Opcode 0, OR: reduction `|A` or `|B` is zero-extended to 2W (same priority as bypass). Otherwise A|B, sign-extended.
- Opcode 1, XOR: same structure as opcode 0, using `^`.
- Opcode 2, ADD: sext(A)+sext(B)+cin. Drop cin when FULL_ADDER = "OFF". Cannot overflow 2W.
- Opcode 3, MUL: full signed product A*B in 2W bits, exact.
- Opcode 4, SHIFT:
  - Left: {out[2W-2:0], serial_in}.
  - Right: {serial_in, out[2W-1:1]}.
- Opcode 5, ROTATE:
  - Left: {out[2W-2:0], out[2W-1]}.
  - Right: {out[0], out[2W-1:1]}.
- Opcode 6, ACCUMULATE: out + sext(A), wrapping modulo 2^(2W).
- Opcodes 4–6 use the current `out`, which may be a bypass or invalid result. Back-to-back opcode-4/5/6 operations chain on each other.

## Timing
- Reset values: `out` = 0, `out_valid` = 0, `err` = 0, `leds` = 0. All input registers and `v1` are also 0.
- Reset is asynchronous: it clears mid-operation. An operation captured before reset produces no `out_valid`.
- Latency: inputs sampled at edge E with `in_valid` = 1 give `out` and `out_valid` valid after edge E+1.
- Throughput is one operation per cycle; there is no backpressure.
- `out_valid` is high for exactly one cycle per captured operation. Consecutive valid inputs give consecutive pulses.
- Gaps (`in_valid` = 0) insert no operations: `out` holds, so a later shift or rotate resumes from the held value.

## Test plan
- Assert `rst` mid-stream with `in_valid` = 1 the cycle before → all outputs 0 immediately. No `out_valid` pulse follows the release of reset.
- W = 3, opcode 3, A = −3, B = 2 → `out` = 6'b111010 (−6) with a one-cycle `out_valid`, 2 edges after capture.
- W = 3, opcode 2, A = 3, B = 3, cin = 1 → `out` = 7.
- Same, FULL_ADDER = "OFF" → `out` = 6.
- Opcode 7 on two consecutive valid cycles → `out` = 0, `err` = 1, `leds` go 16'hFFFF then 16'h0000. A valid opcode 0 next clears `err` and `leds`.
- Bypass with A = 3, then opcode 4 with direction = 1, serial_in = 1 → `out` 6'b000011 → 6'b000111. Then opcode 5 with direction = 0 → 6'b100011.
- Opcode 6 twice from `out` = 0 with A = −1 → 6'b111111, then 6'b111110. Insert an `in_valid` = 0 gap between them → `out` holds and no `out_valid` pulse occurs during the gap.
